hilo_acc_reg: RTL

- Parametrised HI/LO register pair with an iterative accumulate path.
- Adds two things to the plain HI/LO pair: a 2W-bit multiply-accumulate/subtract (MADD/MSUB) and a pipeline flush that cancels an in-flight accumulate.
- Sits in ID beside the GPR file. The EX/MEM writeback side drives ops; ID reads hi_o/lo_o for MFHI/MFLO.
- Simple writes forward combinationally. Accumulates are split into low-half then high-half adds, so no 2W-bit adder sits in a single cycle.

---
 rtl/hilo_acc_reg.sv | 127 ++++++++++++
 1 files changed

// File: rtl/hilo_acc_reg.sv
// HI/LO register pair with write-through forwarding and a two-cycle
// multiply-accumulate/subtract path (low half first, high half second).
// A flush cancels the presented op and any accumulate still in flight.
module hilo_acc_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              flush,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_LO = 2'd1,
        ACC_HI = 2'd2
    } state_t;

    localparam logic [2:0] OP_WHI   = 3'd1;
    localparam logic [2:0] OP_WLO   = 3'd2;
    localparam logic [2:0] OP_WBOTH = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MSUB  = 3'd5;

    state_t              state;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;
    logic [2*DATA_W-1:0] opnd;
    logic                sub;
    logic [DATA_W-1:0]   tmp_lo;
    logic                cy;

    logic                accept;
    logic                wr_hi;
    logic                wr_lo;
    logic                start_acc;
    logic [DATA_W:0]     lo_sum;
    logic [DATA_W-1:0]   hi_sum;
    logic [DATA_W-1:0]   cy_ext;

    assign op_ready  = rst_n & (state == IDLE);
    assign busy      = rst_n & (state != IDLE);
    assign accept    = op_valid & op_ready & ~flush;
    assign wr_hi     = accept & ((op == OP_WHI) | (op == OP_WBOTH));
    assign wr_lo     = accept & ((op == OP_WLO) | (op == OP_WBOTH));
    assign start_acc = accept & ((op == OP_MADD) | (op == OP_MSUB));
    assign cy_ext    = {{(DATA_W-1){1'b0}}, cy};

    // Half-width adders: low half with carry/borrow out, high half with carry/borrow in.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        lo_sum = '0;
        hi_sum = '0;
        if (sub) begin
            lo_sum = {1'b0, lo} - {1'b0, opnd[DATA_W-1:0]};
            hi_sum = hi - opnd[2*DATA_W-1:DATA_W] - cy_ext;
        end else begin
            lo_sum = {1'b0, lo} + {1'b0, opnd[DATA_W-1:0]};
            hi_sum = hi + opnd[2*DATA_W-1:DATA_W] + cy_ext;
        end
    end

    // Read port: zero in reset, write-through on an accepted write, else stored value.
    always_comb begin
        hi_o = hi;
        lo_o = lo;
        if (!rst_n) begin
            hi_o = '0;
            lo_o = '0;
        end else begin
            if (wr_hi) hi_o = hi_i;
            if (wr_lo) lo_o = lo_i;
        end
    end

    // Register updates and accumulate sequencing.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            // NOTE: operand and carry registers are reset too, so a reset mid-accumulate leaves no residue.
            state  <= IDLE;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            sub    <= 1'b0;
            tmp_lo <= '0;
            cy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_hi) hi <= hi_i;
                    if (wr_lo) lo <= lo_i;
                    if (start_acc) begin
                        opnd  <= {hi_i, lo_i};
                        sub   <= (op == OP_MSUB);
                        state <= ACC_LO;
                    end
                end
                ACC_LO: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        tmp_lo <= lo_sum[DATA_W-1:0];
                        cy     <= lo_sum[DATA_W];
                        state  <= ACC_HI;
                    end
                end
                ACC_HI: begin
                    if (!flush) begin
                        hi <= hi_sum;
                        lo <= tmp_lo;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
